// File: rtl/lms_ctr_oc_mem_arb.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip memory.
// Round-robin with a bounded lock override; read data returns one cycle after the grant.
module lms_ctr_oc_mem_arb #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

  logic            req0, req1;
  logic            grant0, grant1, gnt_any, gnt_id, gnt_wr, gnt_rd;
  logic            keep_last, sel;

  logic            ptr_q, ptr_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic            last_vld_q, last_vld_d;
  logic            last_id_q, last_id_d;
  logic            tag_vld_q, tag_vld_d;
  logic            tag_id_q, tag_id_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Contention is the only case where the pointer or the lock matters.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    keep_last = 1'b0;
    sel       = ptr_q;
    if (!reset_req) begin
      if (req0 && req1) begin
        keep_last = last_vld_q && (last_id_q ? m1_lock : m0_lock) && (hold_q < HOLD_MAX);
        sel       = keep_last ? last_id_q : ptr_q;
        grant0    = ~sel;
        grant1    = sel;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign gnt_any = grant0 | grant1;
  assign gnt_id  = grant1;
  assign gnt_wr  = grant1 ? m1_write : m0_write;
  assign gnt_rd  = gnt_any & ~gnt_wr;

  // Idle cycles leave the arbitration history untouched; only grants advance it.
  always_comb begin
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    last_vld_d = last_vld_q;
    last_id_d  = last_id_q;
    if (gnt_any) begin
      ptr_d      = ~gnt_id;
      last_vld_d = 1'b1;
      last_id_d  = gnt_id;
      if (last_vld_q && (last_id_q == gnt_id))
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HC_W'(1);
      else
        hold_d = HC_W'(1);
    end
    tag_vld_d = gnt_rd;
    tag_id_d  = gnt_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= 1'b0;
      hold_q     <= '0;
      last_vld_q <= 1'b0;
      last_id_q  <= 1'b0;
      tag_vld_q  <= 1'b0;
      tag_id_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      last_vld_q <= last_vld_d;
      last_id_q  <= last_id_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
    end
  end

  assign m0_waitrequest   = req0 & ~grant0;
  assign m1_waitrequest   = req1 & ~grant1;

  assign mem_address      = grant1 ? m1_address    : m0_address;
  assign mem_byteenable   = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata    = grant1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect   = gnt_any;
  assign mem_write        = gnt_any & gnt_wr;
  assign mem_clken        = ~reset_req;

  // Both masters see the memory bus; the tag decides who is told it is valid.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = tag_vld_q & ~tag_id_q;
  assign m1_readdatavalid = tag_vld_q & tag_id_q;

endmodule

// File: tb/tb_lms_ctr_oc_mem_arb.sv
// Bench for lms_ctr_oc_mem_arb: directed scenarios plus random traffic against
// a cycle-level reference model of the arbitration rules and a reference memory.
module tb_lms_ctr_oc_mem_arb;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_HOLD = 8;
  localparam int DEPTH    = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic reset_req;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, mem_byteenable;
  logic              m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, mem_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  lms_ctr_oc_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Memory behind the arbiter: registered read, byte-lane write, gated by clken.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] init_val [DEPTH];
  logic              load;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val[i];
    end else if (mem_clken) begin
      if (mem_chipselect && mem_write)
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) mem[mem_address[4:0]][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      mem_readdata <= mem[mem_address[4:0]];
    end
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int m_ptr, m_last, m_hold;
  logic [DATA_W+1:0] exp_q[$];  // {valid, master id, data} expected one cycle later

  int n_chk = 0;
  int n_pass = 0;
  int obs_g;
  logic obs_rdv0, obs_rdv1;
  logic [DATA_W-1:0] obs_rd0, obs_rd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_last = -1;
    m_hold = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m0_lock = 0;
    m1_read = 0; m1_write = 0; m1_lock = 0;
  endtask

  // driver: one clock with reset low; inputs already set at posedge+1
  task automatic cycle();
    int e;
    logic r0, r1, wr;
    logic [4:0] a;
    logic [DATA_W+1:0] ent;
    logic [ADDR_W-1:0] ea;
    logic [BE_W-1:0] eb;
    logic [DATA_W-1:0] ed;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    e = -1;
    if (!reset_req) begin
      if (r0 && !r1) e = 0;
      else if (r1 && !r0) e = 1;
      else if (r0 && r1) begin
        if (m_last >= 0 && (m_last == 1 ? m1_lock : m0_lock) && m_hold < MAX_HOLD) e = m_last;
        else e = m_ptr;
      end
    end
    obs_g = (r0 && !m0_waitrequest) ? 0 : ((r1 && !m1_waitrequest) ? 1 : -1);
    check("grant", 64'(obs_g), 64'(e));
    check("m0_wait", m0_waitrequest, r0 && e != 0);
    check("m1_wait", m1_waitrequest, r1 && e != 1);
    check("chipselect", mem_chipselect, e >= 0);
    check("clken", mem_clken, !reset_req);
    wr = 0;
    if (e >= 0) begin
      wr = (e == 1) ? m1_write : m0_write;
      ea = (e == 1) ? m1_address : m0_address;
      eb = (e == 1) ? m1_byteenable : m0_byteenable;
      ed = (e == 1) ? m1_writedata : m0_writedata;
      check("mem_write", mem_write, wr);
      check("mem_address", mem_address, ea);
      if (wr) begin
        check("mem_be", mem_byteenable, eb);
        check("mem_wdata", mem_writedata, ed);
      end
    end else begin
      check("mem_write_idle", mem_write, 0);
    end
    ent = exp_q.pop_front();
    check("rdv0", m0_readdatavalid, ent[DATA_W+1] && !ent[DATA_W]);
    check("rdv1", m1_readdatavalid, ent[DATA_W+1] && ent[DATA_W]);
    if (ent[DATA_W+1])
      check("rdata", ent[DATA_W] ? m1_readdata : m0_readdata, ent[DATA_W-1:0]);
    obs_rdv0 = m0_readdatavalid; obs_rd0 = m0_readdata;
    obs_rdv1 = m1_readdatavalid; obs_rd1 = m1_readdata;
    if (e >= 0) begin
      a = ea[4:0];
      if (wr) begin
        for (int b = 0; b < BE_W; b++) if (eb[b]) ref_mem[a][b*8 +: 8] = ed[b*8 +: 8];
        exp_q.push_back('0);
      end else begin
        exp_q.push_back({1'b1, e[0], ref_mem[a]});
      end
      m_hold = (m_last == e) ? ((m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD) : 1;
      m_last = e;
      m_ptr  = 1 - e;
    end else begin
      exp_q.push_back('0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  logic [DATA_W-1:0] orig;
  int run;
  bit done;

  initial begin
    reset = 1; reset_req = 0; load = 1;
    idle_inputs();
    m0_address = '0; m1_address = '0; m0_byteenable = '1; m1_byteenable = '1;
    m0_writedata = '0; m1_writedata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    repeat (3) @(posedge clk);
    #1;
    load = 0;
    do_reset();

    // reset state: idle bus, nothing valid
    cycle();
    check("reset_cs", mem_chipselect, 0);
    check("reset_rdv", {obs_rdv0, obs_rdv1}, 2'b00);

    // simultaneous reads: m0 first, then m1
    m0_read = 1; m0_address = ADDR_W'(3);
    m1_read = 1; m1_address = ADDR_W'(7);
    cycle();
    check("sim_first", 64'(obs_g), 0);
    m0_read = 0;
    cycle();
    check("sim_second", 64'(obs_g), 1);
    check("sim_rd0", {obs_rdv0, obs_rd0}, {1'b1, ref_mem[3]});
    m1_read = 0;
    cycle();
    check("sim_rd1", {obs_rdv1, obs_rd1}, {1'b1, ref_mem[7]});

    // partial write then read back on the other master
    orig = ref_mem[16];
    m0_write = 1; m0_address = ADDR_W'(16'h10); m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'h3;
    cycle();
    m0_write = 0;
    m1_read = 1; m1_address = ADDR_W'(16'h10);
    cycle();
    m1_read = 0;
    cycle();
    check("be_merge", {obs_rdv1, obs_rd1}, {1'b1, orig[31:16], 16'hBEEF});

    // locked m1 stream bounded by MAX_HOLD against a waiting m0
    do_reset();
    m1_read = 1; m1_lock = 1; m1_address = ADDR_W'(5);
    cycle();
    run = (obs_g == 1) ? 1 : 0;
    m0_read = 1; m0_address = ADDR_W'(9);
    done = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (!done) begin
        if (obs_g == 1) run++;
        else begin
          done = 1;
          check("lock_next", 64'(obs_g), 0);
        end
      end
    end
    check("lock_run", 64'(run), 64'(MAX_HOLD));
    idle_inputs();
    cycle();

    // reset_req gap inside an m0 read stream
    m0_read = 1; m0_address = ADDR_W'(11);
    cycle(); cycle();
    reset_req = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rr_wait", {mem_clken, m0_waitrequest}, 2'b01);
      if (i == 0) check("rr_prior_rdv", obs_rdv0, 1);
    end
    reset_req = 0;
    cycle();
    check("rr_resume", 64'(obs_g), 0);
    cycle();
    idle_inputs();
    cycle();

    // reset in the cycle of a granted m1 read
    m1_read = 1; m1_address = ADDR_W'(2);
    cycle();
    do_reset();
    m1_read = 0;
    cycle();
    check("rst_no_rdv", obs_rdv1, 0);
    m0_read = 1; m1_read = 1;
    cycle();
    check("rst_ptr0", 64'(obs_g), 0);
    idle_inputs();
    cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int k0, k1;
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      m0_read = k0[0]; m0_write = k0[1]; m0_lock = $urandom_range(0, 3) != 0;
      m1_read = k1[0]; m1_write = k1[1]; m1_lock = $urandom_range(0, 3) != 0;
      m0_address = ADDR_W'($urandom_range(0, DEPTH - 1));
      m1_address = ADDR_W'($urandom_range(0, DEPTH - 1));
      m0_byteenable = BE_W'($urandom); m1_byteenable = BE_W'($urandom);
      m0_writedata = $urandom; m1_writedata = $urandom;
      reset_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 79) == 0) begin
        m0_write = 0; m1_write = 0;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
